// File: rtl/alu_unit.sv
// Integer execution stage: combinational compute on the issued op, followed by
// a small in-order result queue whose head is broadcast once the bus is granted.
module alu_unit #(
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      rs_ready,
    input  logic [ALU_OP_WIDTH-1:0]   rs_op,
    input  logic [XLEN-1:0]           rs_val1,
    input  logic [XLEN-1:0]           rs_val2,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
    input  logic                      cdb_grant,
    output logic                      alu_stall,
    output logic                      alu_ready,
    output logic [XLEN-1:0]           alu_res,
    output logic [ROB_SIZE_WIDTH-1:0] alu_id,
    output logic                      alu_overflow
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FIFO_DEPTH - 1);

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHL  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHR  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHRA = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_EQ   = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_NEQ  = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LT   = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LTU  = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_GE   = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] OP_GEU  = ALU_OP_WIDTH'(13);

    logic [XLEN-1:0]           res_mem [FIFO_DEPTH];
    logic [ROB_SIZE_WIDTH-1:0] id_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]          head, tail, head_n;
    logic [CNT_W-1:0]          count, count_n;
    logic                      do_push, do_pop, ovf_n;
    logic [XLEN-1:0]           result, head_res_n;
    logic [ROB_SIZE_WIDTH-1:0] head_id_n;
    logic [XLEN-1:0]           out_res;
    logic [ROB_SIZE_WIDTH-1:0] out_id;
    logic                      overflow_q;
    logic [SH_W-1:0]           shamt;
    logic                      cmp_bit;

    assign shamt = rs_val2[SH_W-1:0];

    // Result of the op currently presented by the reservation station.
    always_comb begin
        result  = '0;
        cmp_bit = 1'b0;
        case (rs_op)
            OP_ADD:  result = rs_val1 + rs_val2;
            OP_SUB:  result = rs_val1 - rs_val2;
            OP_AND:  result = rs_val1 & rs_val2;
            OP_OR:   result = rs_val1 | rs_val2;
            OP_XOR:  result = rs_val1 ^ rs_val2;
            OP_SHL:  result = rs_val1 << shamt;
            OP_SHR:  result = rs_val1 >> shamt;
            OP_SHRA: result = $unsigned($signed(rs_val1) >>> shamt);
            OP_EQ:   cmp_bit = (rs_val1 == rs_val2);
            OP_NEQ:  cmp_bit = (rs_val1 != rs_val2);
            OP_LT:   cmp_bit = ($signed(rs_val1) < $signed(rs_val2));
            OP_LTU:  cmp_bit = (rs_val1 < rs_val2);
            OP_GE:   cmp_bit = ($signed(rs_val1) >= $signed(rs_val2));
            OP_GEU:  cmp_bit = (rs_val1 >= rs_val2);
            default: result = '0;
        endcase
        if (rs_op >= OP_EQ && rs_op <= OP_GEU) begin
            result = {{(XLEN-1){1'b0}}, cmp_bit};
        end
    end

    // Queue control: pop on grant, push unless full without a same-cycle pop,
    // and precompute the entry that will sit at the head after this edge so the
    // bus outputs can be registered without a path from rs_* or cdb_grant.
    always_comb begin
        do_pop  = (count != '0) && cdb_grant;
        do_push = rs_ready && ((count != DEPTH_C) || do_pop);
        ovf_n   = rs_ready && (count == DEPTH_C) && !do_pop;
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
        head_n     = do_pop ? head + PTR_W'(1) : head;
        head_res_n = res_mem[head_n];
        head_id_n  = id_mem[head_n];
        if (do_push && (tail == head_n)) begin
            head_res_n = result;
            head_id_n  = rs_id;
        end
    end

    // Queue state and registered bus outputs; flush clears occupancy but keeps
    // the last broadcast value since it is masked by alu_ready anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            overflow_q <= 1'b0;
            out_res    <= '0;
            out_id     <= '0;
        end else if (flush) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                res_mem[tail] <= result;
                id_mem[tail]  <= rs_id;
                tail          <= tail + PTR_W'(1);
            end
            head       <= head_n;
            count      <= count_n;
            overflow_q <= ovf_n;
            out_res    <= head_res_n;
            out_id     <= head_id_n;
        end
    end

    assign alu_ready    = (count != '0);
    assign alu_stall    = (count >= LAST_C);
    assign alu_res      = out_res;
    assign alu_id       = out_id;
    assign alu_overflow = overflow_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: compute results, queue ordering, backpressure,
// overflow, simultaneous push/pop, flush and reset.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst, flush, rs_ready, cdb_grant;
    logic [3:0]  rs_op;
    logic [31:0] rs_val1, rs_val2;
    logic [3:0]  rs_id;
    logic        alu_stall, alu_ready, alu_overflow;
    logic [31:0] alu_res;
    logic [3:0]  alu_id;

    int total = 0;
    int bad   = 0;

    alu_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .rs_ready(rs_ready),
        .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id),
        .cdb_grant(cdb_grant), .alu_stall(alu_stall), .alu_ready(alu_ready),
        .alu_res(alu_res), .alu_id(alu_id), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] id);
        rs_ready = v;
        rs_op    = op;
        rs_val1  = a;
        rs_val2  = b;
        rs_id    = id;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        step(); step();
        rst = 1'b0;
        total++;
        if ({alu_ready, alu_stall, alu_overflow, alu_res, alu_id} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b stall=%b ovf=%b res=%h id=%h want all 0",
                     alu_ready, alu_stall, alu_overflow, alu_res, alu_id);
        end
    endtask

    task automatic test_latency();
        cdb_grant = 1'b1;
        set_op(1'b1, 4'd0, 32'd5, 32'd7, 4'd3);
        step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        total++;
        if (alu_ready !== 1'b1 || alu_res !== 32'd12 || alu_id !== 4'd3) begin
            bad++;
            $display("FAIL add_latency got rdy=%b res=%0d id=%0d want rdy=1 res=12 id=3",
                     alu_ready, alu_res, alu_id);
        end
        step();
        total++;
        if (alu_ready !== 1'b0) begin
            bad++;
            $display("FAIL add_pop got rdy=%b want 0", alu_ready);
        end
    endtask

    // Back-to-back issue with continuous grant: each cycle's head is the op
    // issued on the previous edge.
    task automatic test_compute();
        logic [3:0]  t_op [14] = '{4'd7, 4'd6, 4'd5, 4'd10, 4'd11, 4'd13, 4'd1,
                                   4'd15, 4'd2, 4'd4, 4'd8, 4'd9, 4'd12, 4'd3};
        logic [31:0] t_a  [14] = '{32'h80000000, 32'h80000000, 32'h1, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'h0, 32'h0, 32'h5, 32'hF0F0, 32'hFF,
                                   32'h3, 32'h3, 32'hFFFFFFFF, 32'h1};
        logic [31:0] t_b  [14] = '{32'd4, 32'd4, 32'd33, 32'd1, 32'd1, 32'd0, 32'd1,
                                   32'd7, 32'hFF00, 32'h0F, 32'h3, 32'h3, 32'h1, 32'h2};
        logic [31:0] t_e  [14] = '{32'hF8000000, 32'h08000000, 32'h2, 32'h1, 32'h0,
                                   32'h1, 32'hFFFFFFFF, 32'h0, 32'hF000, 32'hF0,
                                   32'h1, 32'h0, 32'h0, 32'h3};
        cdb_grant = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_op(1'b1, t_op[i], t_a[i], t_b[i], 4'(i));
            step();
            total++;
            if (alu_ready !== 1'b1 || alu_res !== t_e[i] || alu_id !== 4'(i)) begin
                bad++;
                $display("FAIL compute_op%0d got rdy=%b res=%h id=%0d want rdy=1 res=%h id=%0d",
                         t_op[i], alu_ready, alu_res, alu_id, t_e[i], i);
            end
        end
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        step();
        total++;
        if (alu_ready !== 1'b0 || alu_stall !== 1'b0) begin
            bad++;
            $display("FAIL compute_drain got rdy=%b stall=%b want 0 0", alu_ready, alu_stall);
        end
    endtask

    task automatic test_backpressure();
        cdb_grant = 1'b0;
        set_op(1'b1, 4'd0, 32'd10, 32'd1, 4'd1);
        step();
        total++;
        if (alu_stall !== 1'b1 || alu_ready !== 1'b1 || alu_id !== 4'd1 || alu_res !== 32'd11) begin
            bad++;
            $display("FAIL bp_first got stall=%b rdy=%b id=%0d res=%0d want 1 1 1 11",
                     alu_stall, alu_ready, alu_id, alu_res);
        end
        set_op(1'b1, 4'd0, 32'd20, 32'd2, 4'd2);
        step();
        total++;
        if (alu_stall !== 1'b1 || alu_id !== 4'd1 || alu_res !== 32'd11 || alu_overflow !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got stall=%b id=%0d res=%0d ovf=%b want 1 1 11 0",
                     alu_stall, alu_id, alu_res, alu_overflow);
        end
        set_op(1'b1, 4'd0, 32'd30, 32'd3, 4'd3);
        step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        total++;
        if (alu_overflow !== 1'b1 || alu_id !== 4'd1) begin
            bad++;
            $display("FAIL bp_overflow got ovf=%b id=%0d want 1 1", alu_overflow, alu_id);
        end
        step();
        total++;
        if (alu_overflow !== 1'b0 || alu_id !== 4'd1 || alu_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ovf_pulse got ovf=%b id=%0d rdy=%b want 0 1 1",
                     alu_overflow, alu_id, alu_ready);
        end
        cdb_grant = 1'b1;
        step();
        total++;
        if (alu_ready !== 1'b1 || alu_id !== 4'd2 || alu_res !== 32'd22 || alu_stall !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got rdy=%b id=%0d res=%0d stall=%b want 1 2 22 1",
                     alu_ready, alu_id, alu_res, alu_stall);
        end
        step();
        total++;
        if (alu_ready !== 1'b0 || alu_stall !== 1'b0) begin
            bad++;
            $display("FAIL bp_dropped got rdy=%b stall=%b want 0 0 (id3 must be dropped)",
                     alu_ready, alu_stall);
        end
    endtask

    task automatic test_back_to_back();
        cdb_grant = 1'b0;
        set_op(1'b1, 4'd0, 32'd4, 32'd0, 4'd4);
        step();
        set_op(1'b1, 4'd0, 32'd5, 32'd0, 4'd5);
        step();
        set_op(1'b1, 4'd0, 32'd6, 32'd0, 4'd6);
        cdb_grant = 1'b1;
        step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        total++;
        if (alu_ready !== 1'b1 || alu_id !== 4'd5 || alu_res !== 32'd5 ||
            alu_stall !== 1'b1 || alu_overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_pushpop got rdy=%b id=%0d res=%0d stall=%b ovf=%b want 1 5 5 1 0",
                     alu_ready, alu_id, alu_res, alu_stall, alu_overflow);
        end
        step();
        total++;
        if (alu_ready !== 1'b1 || alu_id !== 4'd6 || alu_res !== 32'd6) begin
            bad++;
            $display("FAIL full_pushed got rdy=%b id=%0d res=%0d want 1 6 6",
                     alu_ready, alu_id, alu_res);
        end
        step();
        total++;
        if (alu_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_drain got rdy=%b want 0", alu_ready);
        end
    endtask

    task automatic test_flush_reset();
        cdb_grant = 1'b0;
        set_op(1'b1, 4'd0, 32'd7, 32'd0, 4'd7);
        step();
        set_op(1'b1, 4'd0, 32'd8, 32'd0, 4'd8);
        step();
        flush = 1'b1;
        cdb_grant = 1'b1;
        set_op(1'b1, 4'd0, 32'd9, 32'd0, 4'd9);
        step();
        flush = 1'b0;
        cdb_grant = 1'b0;
        total++;
        if (alu_ready !== 1'b0 || alu_stall !== 1'b0 || alu_overflow !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear got rdy=%b stall=%b ovf=%b want 0 0 0",
                     alu_ready, alu_stall, alu_overflow);
        end
        set_op(1'b1, 4'd0, 32'd1, 32'd1, 4'd10);
        step();
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        total++;
        if (alu_ready !== 1'b1 || alu_id !== 4'd10 || alu_res !== 32'd2 || alu_stall !== 1'b1) begin
            bad++;
            $display("FAIL flush_after got rdy=%b id=%0d res=%0d stall=%b want 1 10 2 1",
                     alu_ready, alu_id, alu_res, alu_stall);
        end
        rst = 1'b1;
        flush = 1'b1;
        cdb_grant = 1'b1;
        set_op(1'b1, 4'd0, 32'd3, 32'd3, 4'd11);
        step();
        total++;
        if ({alu_ready, alu_stall, alu_overflow, alu_res, alu_id} !== 39'd0) begin
            bad++;
            $display("FAIL rst_mid got rdy=%b stall=%b ovf=%b res=%h id=%h want all 0",
                     alu_ready, alu_stall, alu_overflow, alu_res, alu_id);
        end
        rst = 1'b0;
        flush = 1'b0;
        set_op(1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_compute();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
